// File: rtl/fixed_point_div_normalizer.sv
// -----------------------------------------------------------------------------
// fixed_point_div_normalizer
//
// Purpose:
//   This block is the operand pre-normalizer for the unsigned fixed-point
//   long divider. It accepts a dividend/divisor pair over a valid/ready
//   handshake. It then shifts the divisor left one bit per cycle until the
//   divisor MSB is set.
//
//   The result it presents holds:
//     - the unmodified dividend,
//     - the normalized divisor,
//     - the number of shifts applied,
//     - a divide-by-zero flag.
//
//   The divider uses the shift count to re-scale its quotient. Consecutive
//   pairs never overlap.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset_n      synchronous, active-low reset
//   i_valid        upstream operand pair valid
//   o_ready        block is idle and can accept a pair
//   i_dividend     unsigned dividend (any Q format)
//   i_divisor      unsigned divisor (same Q format as dividend)
//   o_valid        normalized result valid
//   i_ready        downstream divider accepts the result
//   o_dividend     captured dividend, unmodified
//   o_divisor      divisor << o_shift; MSB set unless divide-by-zero
//   o_shift        leading zeros removed from the divisor, 0..DATA_W-1
//   o_div_by_zero  captured divisor was zero
// -----------------------------------------------------------------------------
module fixed_point_div_normalizer #(
  parameter  int DATA_W  = 8,
  localparam int SHIFT_W = $clog2(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_dividend,
  input  logic [DATA_W-1:0]  i_divisor,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_dividend,
  output logic [DATA_W-1:0]  o_divisor,
  output logic [SHIFT_W-1:0] o_shift,
  output logic               o_div_by_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  dividend_q, dividend_d;
  logic [DATA_W-1:0]  divisor_q,  divisor_d;
  logic [SHIFT_W-1:0] shift_q,    shift_d;
  logic               dbz_q,      dbz_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      shift_q    <= '0;
      dbz_q      <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      shift_q    <= shift_d;
      dbz_q      <= dbz_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given its hold value first, so no path through the
  // case statement leaves a signal unassigned. This prevents a latch.
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    shift_d    = shift_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          dividend_d = i_dividend;
          divisor_d  = i_divisor;
          shift_d    = '0;
          dbz_d      = (i_divisor == '0);
          // A zero divisor can never be normalized.
          // A divisor that already has its MSB set needs no shifting.
          // Both cases go straight to HOLD.
          if ((i_divisor == '0) || i_divisor[DATA_W-1]) begin
            state_d = HOLD;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        divisor_d = {divisor_q[DATA_W-2:0], 1'b0};
        shift_d   = shift_q + SHIFT_W'(1);
        // Look at the bit that becomes the MSB after this shift.
        // Leaving SHIFT on that bit means the shift count stops at
        // DATA_W-1 or less.
        if (divisor_q[DATA_W-2]) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ready       = (state_q == IDLE);
    o_valid       = (state_q == HOLD);
    o_dividend    = dividend_q;
    o_divisor     = divisor_q;
    o_shift       = shift_q;
    o_div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_fixed_point_div_normalizer.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_div_normalizer
//
// Purpose:
//   Directed-vector bench for fixed_point_div_normalizer with DATA_W = 8.
//   The expected values are either computed by hand or taken from a
//   leading-zero count model.
//
// Timing:
//   Inputs are driven 1 ns after the rising edge. Outputs are sampled at that
//   same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_fixed_point_div_normalizer;

  localparam int DATA_W  = 8;
  localparam int SHIFT_W = $clog2(DATA_W);
  localparam int MAX_LAT = 4 * DATA_W;

  logic               i_clk;
  logic               i_reset_n;
  logic               i_valid;
  logic               o_ready;
  logic [DATA_W-1:0]  i_dividend;
  logic [DATA_W-1:0]  i_divisor;
  logic               o_valid;
  logic               i_ready;
  logic [DATA_W-1:0]  o_dividend;
  logic [DATA_W-1:0]  o_divisor;
  logic [SHIFT_W-1:0] o_shift;
  logic               o_div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;
  bit streaming = 1'b0;

  fixed_point_div_normalizer #(.DATA_W(DATA_W)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_dividend    (o_dividend),
    .o_divisor     (o_divisor),
    .o_shift       (o_shift),
    .o_div_by_zero (o_div_by_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Output handshakes seen while the streaming section runs.
  always @(posedge i_clk) begin
    if (streaming && o_valid && i_ready) n_hs <= n_hs + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Leading-zero count of a non-zero value. Returns 0 for a zero value,
  // which matches the shift count expected on divide-by-zero.
  function automatic int lz(input logic [DATA_W-1:0] v);
    int n = 0;
    if (v == '0) return 0;
    for (int b = DATA_W - 1; b >= 0; b--) begin
      if (v[b]) break;
      n++;
    end
    return n;
  endfunction

  // Accept edge already taken. Counts cycles until o_valid rises, up to
  // MAX_LAT cycles.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < MAX_LAT) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction: accept, check latency and result, then complete the
  // output handshake.
  task automatic run_pair(input string tag,
                          input logic [DATA_W-1:0] dvd,
                          input logic [DATA_W-1:0] dvs,
                          input logic [DATA_W-1:0] exp_dvs,
                          input int                exp_sh,
                          input logic              exp_dbz,
                          input int                exp_lat);
    int lat;
    check({tag, " ready"}, o_ready, 1);
    i_valid    = 1'b1;
    i_dividend = dvd;
    i_divisor  = dvs;
    tick();
    i_valid    = 1'b0;
    i_dividend = 8'hEE;
    i_divisor  = 8'h11;
    wait_valid(lat);
    check({tag, " latency"},  lat,           exp_lat);
    check({tag, " valid"},    o_valid,       1);
    check({tag, " dividend"}, o_dividend,    dvd);
    check({tag, " divisor"},  o_divisor,     exp_dvs);
    check({tag, " shift"},    o_shift,       exp_sh);
    check({tag, " dbz"},      o_div_by_zero, exp_dbz);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, " valid drop"}, o_valid, 0);
    check({tag, " ready back"}, o_ready, 1);
  endtask

  logic [DATA_W-1:0] seq [12];

  initial begin
    int lat;
    i_reset_n  = 1'b0;
    i_valid    = 1'b1;
    i_ready    = 1'b0;
    i_dividend = 8'hAA;
    i_divisor  = 8'h80;

    // Reset beats a simultaneous accept.
    tick();
    check("rst ready",    o_ready,       1);
    check("rst valid",    o_valid,       0);
    check("rst dividend", o_dividend,    0);
    check("rst divisor",  o_divisor,     0);
    check("rst shift",    o_shift,       0);
    check("rst dbz",      o_div_by_zero, 0);
    tick();
    i_valid   = 1'b0;
    i_reset_n = 1'b1;
    tick();

    // Directed pairs. The expected latency is 1 + leading zeros.
    run_pair("msb set",  8'h3C, 8'h80, 8'h80, 0, 1'b0, 1);
    run_pair("lsb only", 8'hFF, 8'h01, 8'h80, 7, 1'b0, 8);
    run_pair("zero div", 8'h12, 8'h00, 8'h00, 0, 1'b1, 1);
    run_pair("after dbz", 8'h34, 8'h40, 8'h80, 1, 1'b0, 2);

    // Backpressure: 0x05 has 5 leading zeros, so the result is 0xA0 with
    // shift 5 after 6 cycles. New data arriving on i_valid must be ignored.
    i_valid = 1'b1; i_dividend = 8'h77; i_divisor = 8'h05;
    tick();
    i_valid = 1'b0;
    wait_valid(lat);
    check("bp latency", lat, 6);
    for (int c = 0; c < 10; c++) begin
      i_valid    = c[0];
      i_dividend = 8'(c * 17);
      i_divisor  = 8'(c + 1);
      tick();
      check("bp divisor",  o_divisor,  8'hA0);
      check("bp shift",    o_shift,    5);
      check("bp dividend", o_dividend, 8'h77);
      check("bp ready",    o_ready,    0);
      check("bp valid",    o_valid,    1);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("bp valid drop", o_valid, 0);
    check("bp ready back", o_ready, 1);

    // Reset mid-SHIFT: 0x01 needs 7 shifts, and reset is applied after 2.
    i_valid = 1'b1; i_dividend = 8'h5A; i_divisor = 8'h01;
    tick();
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    check("abort shifting", o_valid, 0);
    tick();
    check("abort shifting2", o_valid, 0);
    i_reset_n = 1'b0;
    tick();
    check("abort valid",    o_valid,       0);
    check("abort ready",    o_ready,       1);
    check("abort dividend", o_dividend,    0);
    check("abort divisor",  o_divisor,     0);
    check("abort shift",    o_shift,       0);
    check("abort dbz",      o_div_by_zero, 0);
    i_reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("abort never valid", o_valid, 0);
    end
    i_ready = 1'b0;
    run_pair("post abort", 8'h21, 8'h20, 8'h80, 2, 1'b0, 3);

    // Streaming: i_valid and i_ready are both held high.
    seq[0] = 8'h00; seq[1] = 8'h01; seq[2] = 8'hFF; seq[3] = 8'h00;
    for (int j = 4; j < 12; j++) seq[j] = 8'($urandom_range(0, 255));
    streaming  = 1'b1;
    i_valid    = 1'b1;
    i_ready    = 1'b1;
    i_dividend = 8'h00;
    i_divisor  = seq[0];
    for (int j = 0; j < 12; j++) begin
      int k;
      logic [DATA_W-1:0] exp_dvs;
      k       = lz(seq[j]);
      exp_dvs = seq[j] << k;
      check("str ready", o_ready, 1);
      tick();
      // From here on the inputs are not sampled until the block is back
      // in IDLE, so the next pair can be staged now.
      i_dividend = 8'(j + 1);
      i_divisor  = (j < 11) ? seq[j + 1] : 8'h00;
      wait_valid(lat);
      check("str latency",  lat,           1 + k);
      check("str dividend", o_dividend,    8'(j));
      check("str divisor",  o_divisor,     exp_dvs);
      check("str shift",    o_shift,       k);
      check("str dbz",      o_div_by_zero, (seq[j] == 8'h00));
      tick();
    end
    i_valid = 1'b0;
    tick();
    streaming = 1'b0;
    check("str handshakes", n_hs, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
